toy_uart_mmio: RTL and testbench

Memory-mapped UART peripheral for the toy SoC bus, succeeding the fixed single-register transmit path at 0x0400. It adds a parametrised base address, TX and RX FIFOs, a runtime baud divisor, sticky error flags and a level interrupt. The block sits beside RAM on the CPU's split read/write bus. The SoC read mux selects its data with `o_read_hit`.

---
 rtl/toy_uart_mmio_if.sv | 28 ++
 rtl/toy_uart_mmio.sv | 341 ++++++++++++++++++++++++++++++++++
 tb/tb_toy_uart_mmio.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toy_uart_mmio_if.sv
// Split read/write MMIO bus bundle for the toy SoC UART.
// The slave modport is the UART side; the master modport is the CPU side.
interface toy_uart_mmio_if;
  logic [15:0] i_read_addr;
  logic [15:0] o_read_data;
  logic        o_read_hit;
  logic [15:0] i_write_addr;
  logic [15:0] i_write_data;
  logic        i_we;

  modport slave (
    input  i_read_addr,
    input  i_write_addr,
    input  i_write_data,
    input  i_we,
    output o_read_data,
    output o_read_hit
  );

  modport master (
    output i_read_addr,
    output i_write_addr,
    output i_write_data,
    output i_we,
    input  o_read_data,
    input  o_read_hit
  );
endinterface

// File: rtl/toy_uart_mmio.sv
// MMIO UART: TX/RX FIFOs, runtime divisor, sticky errors, level irq.
// Define TOY_UART_RX_EN to build the receive path.
module toy_uart_mmio #(
  parameter logic [15:0] BASE_ADDR = 16'h0400,
  parameter int          BAUD_DIV  = 217,
  parameter int          TX_DEPTH  = 16,
  parameter int          RX_DEPTH  = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  toy_uart_mmio_if.slave   bus,
  output logic             o_tx,
  input  logic             i_rx,
  output logic             o_irq
);

  localparam int TAW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_st_t;

  logic [15:0] wr_off, rd_off;
  logic        wr_hit;
  logic [15:0] div_q, div_d;
  logic        ie_tx_q, ie_tx_d;
  logic        ie_rx_q, ie_rx_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        rx_fe_q, rx_fe_d;
  logic        clr;

  logic [7:0]     tx_mem_q [TX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_wp_d;
  logic [TAW-1:0] tx_rp_q, tx_rp_d;
  logic [TAW:0]   tx_cnt_q, tx_cnt_d;
  logic           tx_full, tx_empty;
  logic           tx_push, tx_pop, tx_ovf_set;
  logic [7:0]     tx_head;

  tx_st_t      tx_st_q, tx_st_d;
  logic [15:0] tx_tmr_q, tx_tmr_d;
  logic [15:0] tx_dv_q, tx_dv_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_q, tx_d;
  logic        tx_load;

  logic        rx_valid, rx_full;
  logic [7:0]  rx_head;
  logic        rx_ovr_set, rx_fe_set;
  logic [15:0] status;

  assign wr_off = bus.i_write_addr - BASE_ADDR;
  assign rd_off = bus.i_read_addr - BASE_ADDR;
  assign wr_hit = bus.i_we && (wr_off < 16'd4);
  assign clr    = wr_hit && (wr_off[1:0] == 2'd3) && bus.i_write_data[0];

  assign tx_full  = tx_cnt_q == (TAW+1)'(TX_DEPTH);
  assign tx_empty = tx_cnt_q == '0;
  assign tx_head  = tx_mem_q[tx_rp_q];

  always_comb begin
    tx_push    = 1'b0;
    tx_ovf_set = 1'b0;
    if (wr_hit && wr_off[1:0] == 2'd0) begin
      // a pop in the same cycle frees the slot, so the push lands
      tx_push    = !tx_full || tx_pop;
      tx_ovf_set = tx_full && !tx_pop;
    end
    tx_wp_d = tx_push ? tx_wp_q + 1'b1 : tx_wp_q;
    tx_rp_d = tx_pop ? tx_rp_q + 1'b1 : tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    unique case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_tmr_d = tx_tmr_q;
    tx_dv_d  = tx_dv_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_d     = tx_q;
    tx_pop   = 1'b0;
    tx_load  = 1'b0;
    unique case (tx_st_q)
      TX_IDLE: tx_load = !tx_empty;
      TX_START: begin
        if (tx_tmr_q == 16'd0) begin
          tx_st_d  = TX_DATA;
          tx_tmr_d = tx_dv_q - 16'd1;
          tx_d     = tx_sh_q[0];
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_bit_d = 3'd0;
        end else begin
          tx_tmr_d = tx_tmr_q - 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_tmr_q == 16'd0) begin
          tx_tmr_d = tx_dv_q - 16'd1;
          if (tx_bit_q == 3'd7) begin
            tx_st_d = TX_STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d     = tx_sh_q[0];
            tx_sh_d  = {1'b0, tx_sh_q[7:1]};
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end else begin
          tx_tmr_d = tx_tmr_q - 16'd1;
        end
      end
      TX_STOP: begin
        if (tx_tmr_q == 16'd0) begin
          tx_load = !tx_empty;
          if (tx_empty) tx_st_d = TX_IDLE;
        end else begin
          tx_tmr_d = tx_tmr_q - 16'd1;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
    // divisor is captured here so mid-frame writes wait for the next frame
    if (tx_load) begin
      tx_pop   = 1'b1;
      tx_st_d  = TX_START;
      tx_d     = 1'b0;
      tx_sh_d  = tx_head;
      tx_dv_d  = div_q;
      tx_tmr_d = div_q - 16'd1;
    end
  end

`ifdef TOY_UART_RX_EN
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_st_t;

  logic           rx_s1_q, rx_s2_q, rx_prev_q;
  logic [7:0]     rx_mem_q [RX_DEPTH];
  logic [RAW-1:0] rx_wp_q, rx_wp_d;
  logic [RAW-1:0] rx_rp_q, rx_rp_d;
  logic [RAW:0]   rx_cnt_q, rx_cnt_d;
  logic           rx_push, rx_pop;
  rx_st_t         rx_st_q, rx_st_d;
  logic [15:0]    rx_tmr_q, rx_tmr_d;
  logic [15:0]    rx_dv_q, rx_dv_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [7:0]     rx_sh_q, rx_sh_d;

  assign rx_valid = rx_cnt_q != '0;
  assign rx_full  = rx_cnt_q == (RAW+1)'(RX_DEPTH);
  assign rx_head  = rx_mem_q[rx_rp_q];
  assign rx_pop   = wr_hit && (wr_off[1:0] == 2'd1) && rx_valid;

  always_comb begin
    rx_wp_d = rx_push ? rx_wp_q + 1'b1 : rx_wp_q;
    rx_rp_d = rx_pop ? rx_rp_q + 1'b1 : rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    unique case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_comb begin
    rx_st_d    = rx_st_q;
    rx_tmr_d   = rx_tmr_q;
    rx_dv_d    = rx_dv_q;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    rx_ovr_set = 1'b0;
    rx_fe_set  = 1'b0;
    unique case (rx_st_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_st_d  = RX_START;
          rx_dv_d  = div_q;
          rx_tmr_d = (div_q >> 1) - 16'd1;
        end
      end
      RX_START: begin
        if (rx_tmr_q == 16'd0) begin
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
          rx_tmr_d = rx_dv_q - 16'd1;
          rx_bit_d = 3'd0;
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_tmr_q == 16'd0) begin
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          rx_tmr_d = rx_dv_q - 16'd1;
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_tmr_q == 16'd0) begin
          rx_st_d    = RX_IDLE;
          rx_fe_set  = !rx_s2_q;
          rx_ovr_set = rx_s2_q && rx_full;
          rx_push    = rx_s2_q && !rx_full;
        end else begin
          rx_tmr_d = rx_tmr_q - 16'd1;
        end
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
      rx_cnt_q  <= '0;
      rx_st_q   <= RX_IDLE;
      rx_tmr_q  <= '0;
      rx_dv_q   <= '0;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
    end else begin
      rx_s1_q   <= i_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_st_q   <= rx_st_d;
      rx_tmr_q  <= rx_tmr_d;
      rx_dv_q   <= rx_dv_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_sh_q;
  end
`else
  logic unused_rx;
  assign unused_rx  = i_rx;
  assign rx_valid   = 1'b0;
  assign rx_full    = 1'b0;
  assign rx_head    = 8'd0;
  assign rx_ovr_set = 1'b0;
  assign rx_fe_set  = 1'b0;
`endif

  always_comb begin
    div_d   = div_q;
    ie_tx_d = ie_tx_q;
    ie_rx_d = ie_rx_q;
    if (wr_hit && wr_off[1:0] == 2'd2) begin
      div_d = (bus.i_write_data < 16'd2) ? 16'd2 : bus.i_write_data;
    end
    if (wr_hit && wr_off[1:0] == 2'd3) begin
      ie_tx_d = bus.i_write_data[1];
      ie_rx_d = bus.i_write_data[2];
    end
    tx_ovf_d = (tx_ovf_q && !clr) || tx_ovf_set;
    rx_ovr_d = (rx_ovr_q && !clr) || rx_ovr_set;
    rx_fe_d  = (rx_fe_q && !clr) || rx_fe_set;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_q    <= 16'(BAUD_DIV);
      ie_tx_q  <= 1'b0;
      ie_rx_q  <= 1'b0;
      tx_ovf_q <= 1'b0;
      rx_ovr_q <= 1'b0;
      rx_fe_q  <= 1'b0;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      tx_st_q  <= TX_IDLE;
      tx_tmr_q <= '0;
      tx_dv_q  <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      div_q    <= div_d;
      ie_tx_q  <= ie_tx_d;
      ie_rx_q  <= ie_rx_d;
      tx_ovf_q <= tx_ovf_d;
      rx_ovr_q <= rx_ovr_d;
      rx_fe_q  <= rx_fe_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      tx_st_q  <= tx_st_d;
      tx_tmr_q <= tx_tmr_d;
      tx_dv_q  <= tx_dv_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      tx_q     <= tx_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= bus.i_write_data[7:0];
  end

  assign status = {8'(tx_cnt_q), 1'b0, rx_fe_q, rx_ovr_q,
                   tx_ovf_q, rx_full, rx_valid,
                   tx_empty && (tx_st_q == TX_IDLE), !tx_full};

  always_comb begin
    bus.o_read_hit  = rd_off < 16'd4;
    bus.o_read_data = 16'd0;
    if (bus.o_read_hit) begin
      unique case (rd_off[1:0])
        2'd0:    bus.o_read_data = status;
        2'd1:    bus.o_read_data = {8'd0, rx_valid ? rx_head : 8'd0};
        2'd2:    bus.o_read_data = div_q;
        default: bus.o_read_data = {13'd0, ie_rx_q, ie_tx_q, 1'b0};
      endcase
    end
  end

  assign o_tx  = tx_q;
  assign o_irq = (ie_tx_q && tx_empty) || (ie_rx_q && rx_valid);

endmodule

// File: tb/tb_toy_uart_mmio.sv
// Randomised scoreboard bench for toy_uart_mmio.
// A monitor decodes o_tx frames and checks them against a byte queue.
module tb_toy_uart_mmio;
  localparam logic [15:0] BASE = 16'h0400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx, irq;

  always #5 clk = ~clk;

  toy_uart_mmio_if bus();

  toy_uart_mmio #(
    .BASE_ADDR(BASE), .BAUD_DIV(217),
    .TX_DEPTH(4), .RX_DEPTH(16)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus),
    .o_tx(tx), .i_rx(rx), .o_irq(irq)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sb_q[$];
  logic [7:0] rx_exp[$];
  int mon_div = 217;
  bit mon_off = 1'b0;

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [1:0] off, logic [15:0] d);
    @(negedge clk);
    bus.i_we = 1'b1;
    bus.i_write_addr = BASE + 16'(off);
    bus.i_write_data = d;
    @(posedge clk);
    #1;
    bus.i_we = 1'b0;
  endtask

  task automatic rd_abs(logic [15:0] a, output logic [15:0] d,
                        output logic h);
    @(negedge clk);
    bus.i_read_addr = a;
    #1;
    d = bus.o_read_data;
    h = bus.o_read_hit;
  endtask

  task automatic rd(logic [1:0] off, output logic [15:0] d);
    logic h;
    rd_abs(BASE + 16'(off), d, h);
  endtask

  task automatic wait_idle();
    logic [15:0] s;
    int t;
    t = 0;
    rd(2'd0, s);
    while (!s[1] && t < 3000) begin
      rd(2'd0, s);
      t++;
    end
    chk("tx_idle_reached", {15'd0, s[1]}, 16'd1);
  endtask

  task automatic rx_frame(logic [7:0] b, logic stopv);
    logic [9:0] fr;
    fr = {stopv, b, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (4) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    step(8);
  endtask

  initial begin : mon
    int d;
    logic [7:0] b;
    logic st, sp;
    logic [7:0] e;
    forever begin
      step(1);
      if (tx === 1'b0 && !mon_off) begin
        d = mon_div;
        step(d / 2);
        st = tx;
        for (int i = 0; i < 8; i++) begin
          step(d);
          b[i] = tx;
        end
        step(d);
        sp = tx;
        chk("tx_start_stop", {14'd0, st, sp}, 16'h0001);
        if (sb_q.size() == 0) begin
          chk("tx_unexpected_frame", {8'd0, b}, 16'hFFFF);
        end else begin
          e = sb_q.pop_front();
          chk("tx_byte", {8'd0, b}, {8'd0, e});
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [15:0] s;
    logic h;
    logic [7:0] b;
    logic [9:0] fr;
    int errs, d, n;

    bus.i_we = 1'b0;
    bus.i_write_addr = 16'h0;
    bus.i_write_data = 16'h0;
    bus.i_read_addr = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    rd(2'd0, s); chk("rst_status", s, 16'h0003);
    chk("rst_tx", {15'd0, tx}, 16'd1);
    chk("rst_irq", {15'd0, irq}, 16'd0);
    rd(2'd2, s); chk("rst_div", s, 16'd217);
    rd(2'd1, s); chk("rst_rxdata", s, 16'd0);
    rd(2'd3, s); chk("rst_ctrl", s, 16'd0);
    rd_abs(BASE + 16'd3, s, h); chk("hit_top", {15'd0, h}, 16'd1);
    rd_abs(BASE + 16'd4, s, h); chk("miss_hi", {s[14:0], h}, 16'd0);
    rd_abs(BASE - 16'd1, s, h); chk("miss_lo", {s[14:0], h}, 16'd0);

    wr(2'd2, 16'd1); rd(2'd2, s); chk("div_min1", s, 16'd2);
    wr(2'd2, 16'd0); rd(2'd2, s); chk("div_min0", s, 16'd2);
    wr(2'd2, 16'd4); mon_div = 4;
    rd(2'd2, s); chk("div_4", s, 16'd4);

    sb_q.push_back(8'h55);
    wr(2'd0, 16'h0055);
    chk("tx_before_start", {15'd0, tx}, 16'd1);
    fr = {1'b1, 8'h55, 1'b0};
    errs = 0;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (c == 0) chk("tx_start_latency", {15'd0, tx}, 16'd0);
      if (tx !== fr[c / 4]) errs++;
    end
    chk("tx_55_waveform", 16'(errs), 16'd0);
    wait_idle();
    rd(2'd0, s); chk("status_after_55", s, 16'h0003);

    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (i < 5) sb_q.push_back(b);
      wr(2'd0, {8'd0, b});
    end
    rd(2'd0, s);
    chk("ovf_flag", {15'd0, s[4]}, 16'd1);
    chk("ovf_count", {8'd0, s[15:8]}, 16'd4);
    chk("ovf_not_ready", {15'd0, s[0]}, 16'd0);
    wr(2'd3, 16'h0001);
    rd(2'd0, s); chk("ovf_cleared", {15'd0, s[4]}, 16'd0);
    wait_idle();
    chk("ovf_sb_drained", 16'(sb_q.size()), 16'd0);

    for (int r = 0; r < 4; r++) begin
      d = int'($urandom_range(2, 7));
      wr(2'd2, 16'(d));
      mon_div = d;
      rd(2'd2, s); chk("div_rand", s, 16'(d));
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        sb_q.push_back(b);
        wr(2'd0, {8'd0, b});
      end
      wait_idle();
    end
    wr(2'd2, 16'd4); mon_div = 4;

    wr(2'd3, 16'h0002);
    chk("irq_tx_empty", {15'd0, irq}, 16'd1);
    b = 8'($urandom);
    sb_q.push_back(b);
    wr(2'd0, {8'd0, b});
    chk("irq_tx_filled", {15'd0, irq}, 16'd0);
    wait_idle();
    wr(2'd3, 16'h0007);
    rd(2'd3, s); chk("ctrl_read", s, 16'h0006);
    wr(2'd3, 16'h0004);
    chk("irq_ie_rx_only", {15'd0, irq}, 16'd0);
    wr(2'd3, 16'h0000);

`ifdef TOY_UART_RX_EN
    rx_frame(8'hA3, 1'b1);
    rd(2'd1, s); chk("rx_a3", s, 16'h00A3);
    rd(2'd0, s); chk("rx_valid", {15'd0, s[2]}, 16'd1);
    wr(2'd3, 16'h0004);
    chk("irq_rx", {15'd0, irq}, 16'd1);
    wr(2'd1, 16'h0000);
    chk("irq_rx_pop", {15'd0, irq}, 16'd0);
    rd(2'd0, s); chk("rx_empty_pop", {15'd0, s[2]}, 16'd0);
    wr(2'd3, 16'h0000);

    rx_frame(8'($urandom), 1'b0);
    rd(2'd0, s); chk("rx_fe", {13'd0, s[6], s[5], s[2]}, 16'h0004);
    rd(2'd1, s); chk("rx_fe_nodata", s, 16'd0);
    wr(2'd3, 16'h0001);

    @(posedge clk); #1; rx = 1'b0;
    @(posedge clk); #1; rx = 1'b1;
    step(60);
    rd(2'd0, s); chk("glitch_status", s, 16'h0003);

    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom);
      rx_exp.push_back(b);
      rx_frame(b, 1'b1);
    end
    while (rx_exp.size() > 0) begin
      b = rx_exp.pop_front();
      rd(2'd1, s); chk("rx_rand", s, {8'd0, b});
      wr(2'd1, 16'h0000);
    end

    for (int i = 0; i < 17; i++) rx_frame(8'(i + 8'h30), 1'b1);
    rd(2'd0, s); chk("rx_full_ovr", {13'd0, s[5], s[3], s[2]}, 16'h0007);
    errs = 0;
    for (int i = 0; i < 16; i++) begin
      rd(2'd1, s);
      if (s !== 16'(i + 8'h30)) errs++;
      wr(2'd1, 16'h0000);
    end
    chk("rx_drain", 16'(errs), 16'd0);
    wr(2'd3, 16'h0001);
`else
    rx_frame(8'hA3, 1'b0);
    rx_frame(8'h5A, 1'b1);
    wr(2'd1, 16'h0000);
    rd(2'd1, s); chk("norx_data", s, 16'd0);
    rd(2'd0, s); chk("norx_status", s, 16'h0003);
`endif

    mon_off = 1'b1;
    wr(2'd0, {8'd0, 8'($urandom)});
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    step(1);
    chk("rst_mid_tx", {15'd0, tx}, 16'd1);
    @(negedge clk); rst = 1'b0;
    rd(2'd0, s); chk("rst_mid_status", s, 16'h0003);
    rd(2'd2, s); chk("rst_mid_div", s, 16'd217);
    step(20);
    chk("rst_mid_tx_hold", {15'd0, tx}, 16'd1);
    mon_off = 1'b0;

    chk("sb_empty", 16'(sb_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
